countdown_timer: RTL and testbench



---
 rtl/countdown_timer.sv | 142 ++++++++++++++
 tb/tb_countdown_timer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Settable hh:mm:ss BCD countdown timer with start/pause control and
// expiry reporting. All outputs come straight from registers.
module countdown_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        start,
    input  logic        pause,
    output logic [23:0] out,
    output logic        running,
    output logic        done,
    output logic        expired,
    output logic        load_err
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] presc_reg, presc_next;
    logic [23:0]      out_reg, out_next;
    logic             running_reg, running_next;
    logic             done_reg, done_next;
    logic             expired_reg, expired_next;
    logic             load_err_reg, load_err_next;

    logic [5:0]       digit_ok;
    logic             load_ok;
    logic [5:0]       borrow;
    logic [23:0]      dec_val;
    logic             expiring;

    // Per-digit BCD range check and one-second decrement with borrow ripple.
    // Odd digits below the hours (sec tens, min tens) wrap to 5, the rest to 9.
    assign borrow[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            localparam logic [3:0] LIM = (gi == 1 || gi == 3) ? 4'd5 : 4'd9;
            logic [3:0] d;
            logic       zero;
            assign d        = out_reg[gi*4 +: 4];
            assign zero     = (d == 4'd0);
            assign digit_ok[gi] = (load_val[gi*4 +: 4] <= 4'd9);
            assign dec_val[gi*4 +: 4] = borrow[gi] ? (zero ? LIM : d - 4'd1) : d;
            if (gi < 5) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & zero;
            end
        end
    endgenerate

    // Hours must stay at or below 23; tens fields of minutes and seconds at or below 5.
    assign load_ok = (&digit_ok)
                  && (load_val[15:12] <= 4'd5)
                  && (load_val[7:4]   <= 4'd5)
                  && ((load_val[23:20] < 4'd2) ||
                      ((load_val[23:20] == 4'd2) && (load_val[19:16] <= 4'd3)));

    // Next-state: counting first, then commands by priority load > expiry > pause > start.
    always_comb begin
        state_next    = state_reg;
        out_next      = out_reg;
        presc_next    = presc_reg;
        expired_next  = expired_reg;
        done_next     = 1'b0;
        load_err_next = 1'b0;
        expiring      = 1'b0;

        if (state_reg == RUN) begin
            if (presc_reg == PRESC_MAX) begin
                presc_next = '0;
                out_next   = dec_val;
                expiring   = (dec_val == 24'h000000);
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end

        if (load) begin
            if (load_ok) begin
                out_next     = load_val;
                presc_next   = '0;
                state_next   = IDLE;
                expired_next = 1'b0;
            end else begin
                // A rejected load freezes the timer for this cycle.
                out_next      = out_reg;
                presc_next    = presc_reg;
                load_err_next = 1'b1;
            end
        end else if (expiring) begin
            state_next   = DONE;
            done_next    = 1'b1;
            expired_next = 1'b1;
        end else if (pause && state_reg == RUN) begin
            // The prescaler keeps its advanced value so the partial second survives.
            state_next = PAUSE;
        end else if (start) begin
            if (state_reg == IDLE && out_reg != 24'h000000) begin
                state_next = RUN;
                presc_next = '0;
            end else if (state_reg == PAUSE) begin
                state_next = RUN;
            end
        end

        running_next = (state_next == RUN);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            out_reg      <= '0;
            running_reg  <= 1'b0;
            done_reg     <= 1'b0;
            expired_reg  <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            out_reg      <= out_next;
            running_reg  <= running_next;
            done_reg     <= done_next;
            expired_reg  <= expired_next;
            load_err_reg <= load_err_next;
        end
    end

    assign out      = out_reg;
    assign running  = running_reg;
    assign done     = done_reg;
    assign expired  = expired_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected output
// events with their cycle stamps, a monitor compares every observed change.
module tb_countdown_timer;

    logic        clk;
    logic        rst;
    logic        load;
    logic [23:0] load_val;
    logic        start;
    logic        pause;
    logic [23:0] out;
    logic        running;
    logic        done;
    logic        expired;
    logic        load_err;

    typedef struct {
        string       name;
        logic [23:0] out;
        logic        running;
        logic        done;
        logic        expired;
        logic        load_err;
        int          at;
    } ev_t;

    ev_t q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  passes = 0;
    bit  mon_en = 0;
    bit  primed = 0;

    countdown_timer #(.TICK_DIV(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .out(out), .running(running),
        .done(done), .expired(expired), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: an event is any change of out/running/expired or a done/load_err pulse.
    logic [23:0] prev_out;
    logic        prev_run, prev_exp;
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (!primed || out !== prev_out || running !== prev_run ||
                expired !== prev_exp || done || load_err) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event cyc=%0d got out=%h run=%b done=%b exp=%b err=%b",
                             cyc, out, running, done, expired, load_err);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (out !== e.out || running !== e.running || done !== e.done ||
                        expired !== e.expired || load_err !== e.load_err || cyc != e.at) begin
                        $display("FAIL %s got out=%h run=%b done=%b exp=%b err=%b cyc=%0d want out=%h run=%b done=%b exp=%b err=%b cyc=%0d",
                                 e.name, out, running, done, expired, load_err, cyc,
                                 e.out, e.running, e.done, e.expired, e.load_err, e.at);
                    end else begin
                        passes++;
                        $display("ok %s out=%h run=%b done=%b exp=%b err=%b cyc=%0d",
                                 e.name, out, running, done, expired, load_err, cyc);
                    end
                end
            end
            primed   = 1;
            prev_out = out;
            prev_run = running;
            prev_exp = expired;
        end
    end

    task automatic exp_ev(input string n, input logic [23:0] o, input logic r,
                          input logic d, input logic x, input logic e, input int at);
        ev_t ev;
        ev.name = n; ev.out = o; ev.running = r; ev.done = d;
        ev.expired = x; ev.load_err = e; ev.at = at;
        q.push_back(ev);
    endtask

    // One-cycle command pulse, driven at a falling edge.
    task automatic pulse(input logic l, input logic [23:0] v, input logic s, input logic p);
        load = l; load_val = v; start = s; pause = p;
        @(negedge clk);
        load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int t;

    initial begin
        rst = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_ev("reset_state", 24'h000000, 0, 0, 0, 0, cyc + 1);
        mon_en = 1;
        idle(2);

        // Basic countdown from 3 seconds to expiry.
        t = cyc + 1; exp_ev("load_000003", 24'h000003, 0, 0, 0, 0, t);
        pulse(1, 24'h000003, 0, 0);
        t = cyc + 1;
        exp_ev("start_run", 24'h000003, 1, 0, 0, 0, t);
        exp_ev("dec_to_2", 24'h000002, 1, 0, 0, 0, t + 4);
        exp_ev("dec_to_1", 24'h000001, 1, 0, 0, 0, t + 8);
        exp_ev("expire", 24'h000000, 0, 1, 1, 0, t + 12);
        pulse(0, 24'h0, 1, 0);
        idle(16);
        pulse(0, 24'h0, 1, 0);   // start ignored in DONE
        pulse(0, 24'h0, 0, 1);   // pause ignored in DONE
        idle(3);

        // Borrow across hours and minutes.
        t = cyc + 1; exp_ev("load_010000", 24'h010000, 0, 0, 0, 0, t);
        pulse(1, 24'h010000, 0, 0);
        t = cyc + 1;
        exp_ev("start_h", 24'h010000, 1, 0, 0, 0, t);
        exp_ev("borrow_hour", 24'h005959, 1, 0, 0, 0, t + 4);
        pulse(0, 24'h0, 1, 0);
        idle(4);
        t = cyc + 1; exp_ev("load_001000", 24'h001000, 0, 0, 0, 0, t);
        pulse(1, 24'h001000, 0, 0);
        t = cyc + 1;
        exp_ev("start_m", 24'h001000, 1, 0, 0, 0, t);
        exp_ev("borrow_min", 24'h000959, 1, 0, 0, 0, t + 4);
        pulse(0, 24'h0, 1, 0);
        idle(4);

        // Pause and resume keep the partial second.
        t = cyc + 1; exp_ev("load_000005", 24'h000005, 0, 0, 0, 0, t);
        pulse(1, 24'h000005, 0, 0);
        t = cyc + 1; exp_ev("start_p", 24'h000005, 1, 0, 0, 0, t);
        pulse(0, 24'h0, 1, 0);
        idle(1);
        t = cyc + 1; exp_ev("pause", 24'h000005, 0, 0, 0, 0, t);
        pulse(0, 24'h0, 0, 1);
        idle(10);
        t = cyc + 1;
        exp_ev("resume", 24'h000005, 1, 0, 0, 0, t);
        exp_ev("resume_dec", 24'h000004, 1, 0, 0, 0, t + 2);
        pulse(0, 24'h0, 1, 0);
        idle(2);

        // Load and start together: load wins, stays IDLE.
        t = cyc + 1; exp_ev("load_beats_start", 24'h000007, 0, 0, 0, 0, t);
        pulse(1, 24'h000007, 1, 0);

        // Rejected loads leave out unchanged.
        t = cyc + 1; exp_ev("rej_006000", 24'h000007, 0, 0, 0, 1, t);
        pulse(1, 24'h006000, 0, 0);
        t = cyc + 1; exp_ev("rej_240000", 24'h000007, 0, 0, 0, 1, t);
        pulse(1, 24'h240000, 0, 0);
        idle(1);
        t = cyc + 1; exp_ev("rej_0000A0", 24'h000007, 0, 0, 0, 1, t);
        pulse(1, 24'h0000A0, 0, 0);
        idle(1);

        // Start with a zero time is ignored.
        t = cyc + 1; exp_ev("load_zero", 24'h000000, 0, 0, 0, 0, t);
        pulse(1, 24'h000000, 0, 0);
        pulse(0, 24'h0, 1, 0);
        idle(6);

        // Pause beats start in RUN; load on the expiry edge beats expiry.
        t = cyc + 1; exp_ev("load_000002", 24'h000002, 0, 0, 0, 0, t);
        pulse(1, 24'h000002, 0, 0);
        t = cyc + 1; exp_ev("start_ps", 24'h000002, 1, 0, 0, 0, t);
        pulse(0, 24'h0, 1, 0);
        idle(1);
        t = cyc + 1; exp_ev("pause_beats_start", 24'h000002, 0, 0, 0, 0, t);
        pulse(0, 24'h0, 1, 1);
        idle(2);
        t = cyc + 1;
        exp_ev("resume2", 24'h000002, 1, 0, 0, 0, t);
        exp_ev("resume2_dec", 24'h000001, 1, 0, 0, 0, t + 2);
        pulse(0, 24'h0, 1, 0);
        idle(5);
        t = cyc + 1; exp_ev("load_on_expiry", 24'h000009, 0, 0, 0, 0, t);
        pulse(1, 24'h000009, 0, 0);
        idle(8);

        // Reset in the middle of a count, then a full-length first second.
        t = cyc + 1; exp_ev("load_rst", 24'h000003, 0, 0, 0, 0, t);
        pulse(1, 24'h000003, 0, 0);
        t = cyc + 1;
        exp_ev("start_rst", 24'h000003, 1, 0, 0, 0, t);
        exp_ev("dec_before_rst", 24'h000002, 1, 0, 0, 0, t + 4);
        pulse(0, 24'h0, 1, 0);
        idle(6);
        t = cyc + 1; exp_ev("mid_reset", 24'h000000, 0, 0, 0, 0, t);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        t = cyc + 1; exp_ev("reload", 24'h000003, 0, 0, 0, 0, t);
        pulse(1, 24'h000003, 0, 0);
        t = cyc + 1;
        exp_ev("restart", 24'h000003, 1, 0, 0, 0, t);
        exp_ev("first_dec_full", 24'h000002, 1, 0, 0, 0, t + 4);
        exp_ev("second_dec", 24'h000001, 1, 0, 0, 0, t + 8);
        exp_ev("expire2", 24'h000000, 0, 1, 1, 0, t + 12);
        pulse(0, 24'h0, 1, 0);
        idle(18);

        // Any expectation still queued never appeared.
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            checks++;
            $display("FAIL missing_%s got no event want out=%h cyc=%0d", e.name, e.out, e.at);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
